// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared types and constants for the ysyx_25020037 instruction fetch unit.
// Included by the interface and the IFU top; holds state encodings and bus widths.
package ysyx_25020037_ifu_pkg;

  localparam int DATA_W          = 32;
  localparam int FU_TO_DU_BUS_WD = 2 * DATA_W;

  localparam logic [1:0]        RESP_OKAY = 2'b00;
  localparam logic [DATA_W-1:0] INST_NOP  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_HOLD = 2'd2,
    S_WAIT = 2'd3
  } ifu_state_e;

  function automatic logic [FU_TO_DU_BUS_WD-1:0] pack_fu_bus(input logic [DATA_W-1:0] pc,
                                                            input logic [DATA_W-1:0] inst);
    return {pc, inst};
  endfunction

endpackage

// File: rtl/ysyx_25020037_ifu_if.sv
// Bundle of the IFU's AXI4-lite read channel, IDU handshake and commit feedback.
// The master modport is the IFU side; slave is the memory/IDU/commit side.
interface ysyx_25020037_ifu_if;
  import ysyx_25020037_ifu_pkg::*;

  logic                       arvalid;
  logic                       arready;
  logic [DATA_W-1:0]          araddr;
  logic                       rvalid;
  logic                       rready;
  logic [DATA_W-1:0]          rdata;
  logic [1:0]                 rresp;
  logic                       idu_ready;
  logic                       ifu_valid;
  logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus;
  logic                       commit_valid;
  logic [DATA_W-1:0]          commit_npc;
  logic                       fetch_err;

  modport master (
    output arvalid, araddr, rready, ifu_valid, fu_to_du_bus, fetch_err,
    input  arready, rvalid, rdata, rresp, idu_ready, commit_valid, commit_npc
  );

  modport slave (
    input  arvalid, araddr, rready, ifu_valid, fu_to_du_bus, fetch_err,
    output arready, rvalid, rdata, rresp, idu_ready, commit_valid, commit_npc
  );

endinterface

// File: rtl/ysyx_25020037_ifu.sv
// Multi-cycle instruction fetch unit: one AXI4-lite read per committed instruction.
// Optional IFU_RRESP_CHECK_EN: error responses raise sticky fetch_err and deliver a zero instruction.
module ysyx_25020037_ifu
  import ysyx_25020037_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_25020037_ifu_if.master bus_io
);

  ifu_state_e                 state_q, state_d;
  logic [DATA_W-1:0]          pc_q, pc_d;
  logic [FU_TO_DU_BUS_WD-1:0] fu_bus_q, fu_bus_d;
  logic                       valid_q, valid_d;
  logic                       arvalid_q, arvalid_d;
  logic [DATA_W-1:0]          fetched_inst;

`ifdef IFU_RRESP_CHECK_EN
  logic err_q, err_d;
  assign fetched_inst = (bus_io.rresp == RESP_OKAY) ? bus_io.rdata : INST_NOP;
`else
  assign fetched_inst = bus_io.rdata;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fu_bus_d = fu_bus_q;
    valid_d  = valid_q;
    unique case (state_q)
      S_AR: begin
        if (arvalid_q && bus_io.arready) state_d = S_R;
      end
      S_R: begin
        if (bus_io.rvalid) begin
          fu_bus_d = pack_fu_bus(pc_q, fetched_inst);
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus_io.idu_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Commit pulses outside this state are deliberately dropped.
        if (bus_io.commit_valid) begin
          pc_d    = bus_io.commit_npc;
          state_d = S_AR;
        end
      end
      default: state_d = S_AR;
    endcase
    // Registered so arvalid is low during reset and rises the cycle after commit.
    arvalid_d = (state_d == S_AR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_AR;
      pc_q      <= RESET_PC;
      fu_bus_q  <= '0;
      valid_q   <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fu_bus_q  <= fu_bus_d;
      valid_q   <= valid_d;
      arvalid_q <= arvalid_d;
    end
  end

`ifdef IFU_RRESP_CHECK_EN
  assign err_d = err_q | ((state_q == S_R) && bus_io.rvalid && (bus_io.rresp != RESP_OKAY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus_io.fetch_err = err_q;
`else
  assign bus_io.fetch_err = 1'b0;
`endif

  assign bus_io.arvalid      = arvalid_q;
  assign bus_io.araddr       = pc_q;
  assign bus_io.rready       = (state_q == S_R);
  assign bus_io.ifu_valid    = valid_q;
  assign bus_io.fu_to_du_bus = fu_bus_q;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Self-checking bench for ysyx_25020037_ifu: directed fetches, then randomized fetch/commit traffic
// compared against a transaction-level model of pc, delivered instruction and sticky error.
module tb_ysyx_25020037_ifu;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model_pc;
  logic        model_err;
  logic [63:0] model_bus;

  ysyx_25020037_ifu_if bus ();

  ysyx_25020037_ifu #(.RESET_PC(RST_PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // What the IDU should see for a response, from the rules rather than the RTL.
  function automatic logic [31:0] exp_inst(input logic [31:0] d, input logic [1:0] resp);
`ifdef IFU_RRESP_CHECK_EN
    return (resp == 2'b00) ? d : 32'h0;
`else
    return d;
`endif
  endfunction

  function automatic logic exp_err_after(input logic prev, input logic [1:0] resp);
`ifdef IFU_RRESP_CHECK_EN
    return prev | (resp != 2'b00);
`else
    return 1'b0 & prev & |resp;
`endif
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 64'(bus.arvalid), 64'd0);
    chk({tag, "_rready"},  64'(bus.rready),  64'd0);
    chk({tag, "_ifu_valid"}, 64'(bus.ifu_valid), 64'd0);
    chk({tag, "_bus"}, bus.fu_to_du_bus, 64'd0);
    chk({tag, "_fetch_err"}, 64'(bus.fetch_err), 64'd0);
  endtask

  // One full fetch: entered with arvalid already high, left one cycle after commit.
  task automatic do_fetch(input int ar_dly, input int r_dly, input logic [31:0] data,
                          input logic [1:0] resp, input int hold_dly, input bit spurious,
                          input int wait_dly, input logic [31:0] npc);
    chk("ar_valid", 64'(bus.arvalid), 64'd1);
    chk("ar_addr", 64'(bus.araddr), 64'(model_pc));
    for (int i = 0; i < ar_dly; i++) begin
      bus.rvalid = 1'($urandom);
      bus.rdata  = $urandom;
      step();
      chk("ar_stable_valid", 64'(bus.arvalid), 64'd1);
      chk("ar_stable_addr", 64'(bus.araddr), 64'(model_pc));
      chk("ar_no_rready", 64'(bus.rready), 64'd0);
    end
    bus.rvalid  = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("ar_done", 64'(bus.arvalid), 64'd0);
    chk("r_rready", 64'(bus.rready), 64'd1);
    for (int i = 0; i < r_dly; i++) begin
      step();
      chk("r_wait_valid", 64'(bus.ifu_valid), 64'd0);
      chk("r_wait_arvalid", 64'(bus.arvalid), 64'd0);
    end
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.rresp  = resp;
    step();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    model_bus  = {model_pc, exp_inst(data, resp)};
    model_err  = exp_err_after(model_err, resp);
    for (int i = 0; i <= hold_dly; i++) begin
      chk("hold_valid", 64'(bus.ifu_valid), 64'd1);
      chk("hold_bus", bus.fu_to_du_bus, model_bus);
      chk("hold_err", 64'(bus.fetch_err), 64'(model_err));
      chk("hold_rready", 64'(bus.rready), 64'd0);
      if (i < hold_dly) begin
        bus.commit_valid = spurious && (i == 0);
        bus.commit_npc   = $urandom;
        step();
        bus.commit_valid = 1'b0;
      end
    end
    bus.idu_ready = 1'b1;
    step();
    bus.idu_ready = 1'b0;
    chk("xfer_valid_low", 64'(bus.ifu_valid), 64'd0);
    for (int i = 0; i < wait_dly; i++) begin
      bus.rvalid = 1'($urandom);
      step();
      bus.rvalid = 1'b0;
      chk("wait_arvalid", 64'(bus.arvalid), 64'd0);
      chk("wait_valid", 64'(bus.ifu_valid), 64'd0);
    end
    bus.commit_valid = 1'b1;
    bus.commit_npc   = npc;
    step();
    bus.commit_valid = 1'b0;
    model_pc = npc;
    chk("commit_arvalid", 64'(bus.arvalid), 64'd1);
    chk("commit_araddr", 64'(bus.araddr), 64'(npc));
  endtask

  initial begin
    bus.arready      = 1'b0;
    bus.rvalid       = 1'b0;
    bus.rdata        = '0;
    bus.rresp        = 2'b00;
    bus.idu_ready    = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_npc   = '0;
    model_pc  = RST_PC;
    model_err = 1'b0;
    model_bus = '0;

    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Directed: basic fetch, AR stall, IDU backpressure, branch target, spurious commit.
    do_fetch(0, 0, 32'h0000_0413, 2'b00, 0, 1'b0, 0, RST_PC + 32'd4);
    do_fetch(5, 0, 32'h1234_5678, 2'b00, 3, 1'b0, 1, 32'h3000_0100);
    do_fetch(0, 2, 32'hDEAD_BEEF, 2'b10, 2, 1'b1, 0, 32'hFFFF_FFFC);
    do_fetch(1, 1, 32'hCAFE_F00D, 2'b00, 1, 1'b1, 2, 32'h0000_0000);
    do_fetch(0, 0, 32'h0000_0013, 2'b00, 0, 1'b0, 0, 32'h8000_0002);

    // Reset while the read is outstanding.
    chk("mid_pre_addr", 64'(bus.araddr), 64'(model_pc));
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("mid_in_r", 64'(bus.rready), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    step();
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hBAD0_BAD0;
    step();
    bus.rvalid = 1'b0;
    chk_reset_outputs("mid_reset_held");
    rst = 1'b0;
    model_pc  = RST_PC;
    model_err = 1'b0;
    step();
    do_fetch(0, 0, 32'h0000_0413, 2'b00, 1, 1'b1, 0, 32'h3000_0008);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] npc;
      logic [1:0]  resp;
      npc  = ($urandom_range(0, 3) == 0) ? $urandom : model_pc + 32'd4;
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_fetch($urandom_range(0, 4), $urandom_range(0, 3), $urandom, resp,
               $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), npc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
